ysyx_23060184_regfile_sb: RTL
=============================

YSYX_23060184_REGFILE_SB -- requirements
Module: ysyx_23060184_regfile_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width; the file holds 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NR_READ, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter CNT_WIDTH, default 2, pending-writer counter width per register.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port wen  input  1  writeback valid.
REQ-008 SHALL have port waddr  input  ADDR_WIDTH  writeback index.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  writeback data.
REQ-010 SHALL have port raddr  input  NR_READ*ADDR_WIDTH  packed read indices; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port rdata  output  NR_READ*DATA_WIDTH  packed read data, same packing.
REQ-012 SHALL have port rbusy  output  NR_READ  per-port flag: indexed register has an outstanding writer.
REQ-013 SHALL have port claim_valid  input  1  issue stage requests a destination register claim.
REQ-014 SHALL have port claim_addr  input  ADDR_WIDTH  claimed destination index.
REQ-015 SHALL have port claim_ready  output  1  claim accepted this cycle when high with claim_valid.
REQ-016 SHALL have port flush  input  1  discard all outstanding claims.

Function
REQ-017 SHALL read combinationally: rdata port i = rf[raddr_i]; index 0 always reads 0.
REQ-018 SHALL write rf[waddr] <= wdata on clk edge when wen=1 and waddr!=0; writes to index 0 are dropped.
REQ-019 SHALL keep, per register r!=0, counter pend[r] (CNT_WIDTH bits); rbusy_i = (pend[raddr_i]!=0), forced 0 for index 0.
REQ-020 SHALL drive claim_ready = 0 iff claim_addr!=0 and pend[claim_addr] is at max (2**CNT_WIDTH-1) and no same-cycle write to claim_addr; otherwise 1. Also 0 when flush=1.
REQ-021 SHALL on accepted claim (claim_valid & claim_ready, addr!=0) increment pend[claim_addr]; claim of index 0 is accepted with no effect.
REQ-022 SHALL on wen=1 to waddr!=0 decrement pend[waddr] if nonzero; at zero it stays zero (no underflow), data still written.
REQ-023 SHALL on simultaneous accepted claim and write to the same register leave pend unchanged (net zero).
REQ-024 SHALL on flush=1 clear every pend to 0 next edge; claims that cycle are ignored; a same-cycle write still updates rf.
REQ-025 SHALL allow all NR_READ ports to address the same register at once with identical results.

Reset
REQ-026 SHALL on rst=1 at clk edge clear every rf entry to 0 and every pend to 0; rst has priority over wen, claim and flush.
REQ-027 SHALL while rst=1 output rdata=0, rbusy=0, claim_ready=0.
REQ-028 SHALL resume normal operation the first edge after rst deasserts; a reset mid-writeback loses that write.

Configuration
REQ-029 SHALL, with YSYX_23060184_RF_BYPASS_EN defined, forward wdata to any read port with wen=1, waddr==raddr_i, waddr!=0 in the same cycle, and compute rbusy_i from the post-decrement counter value.
REQ-030 SHALL, without YSYX_23060184_RF_BYPASS_EN, return the old stored value and pre-decrement rbusy in that case; new value visible next cycle.

Structure
REQ-031 SHALL place the INITIAL_VAL zero constant, default parameter values and the packed-port slice helper width constants in shared package ysyx_23060184_rf_pkg.
REQ-032 SHALL implement the pending counters as one sub-module ysyx_23060184_rf_scoreboard (claim/write/flush inputs, per-register busy vector output); storage and read muxing stay in the top.

Verification
REQ-033 SHALL test: rst, then wen waddr=5 wdata=0xDEADBEEF, next cycle raddr0=5 -> rdata0=0xDEADBEEF; raddr1=0 -> 0; wen waddr=0 wdata=0x1234 -> reading 0 still 0.
REQ-034 SHALL test: claim x7 three times (CNT_WIDTH=2) -> rbusy for x7=1, fourth claim claim_ready=0; one write to x7 -> claim_ready=1 same cycle, pend stays 3 after claim+write.
REQ-035 SHALL test: same-cycle wen x3=0xA5A5A5A5 and raddr0=3 with old value 0x11 -> rdata0=0xA5A5A5A5 with bypass macro, 0x11 without.
REQ-036 SHALL test: claim x4 and x9, assert flush with claim_valid x10 -> next cycle rbusy all 0 for x4, x9, x10.
REQ-037 SHALL test: write x8=0x55, claim x8, assert rst with wen x8=0x66 -> after reset rdata for x8=0, rbusy=0.
REQ-038 SHALL test: NR_READ=4, all ports raddr=12 after write 0xCAFE -> all four rdata=0xCAFE.

Source files
------------

// File: rtl/ysyx_23060184_rf_pkg.sv
// Shared constants for the scoreboarded register file: default sizes, reset value
// and the packed-port slice helper.
package ysyx_23060184_rf_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NR_READ    = 2;
  localparam int DEF_CNT_WIDTH  = 2;
  localparam int MAX_NR_READ    = 4;

  // Replicated to DATA_WIDTH wherever a register or read port is cleared.
  localparam logic INITIAL_VAL = 1'b0;

  // Low bit of port `port` inside a packed bus of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/ysyx_23060184_rf_scoreboard.sv
// Per-register pending-writer counters: claims increment, writebacks decrement, flush clears.
// With YSYX_23060184_RF_BYPASS_EN the busy vector reflects the post-writeback count.
module ysyx_23060184_rf_scoreboard
  import ysyx_23060184_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       claim_valid,
  input  logic [ADDR_WIDTH-1:0]      claim_addr,
  output logic                       claim_ready,
  input  logic                       wen,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic                       flush,
  output logic [2**ADDR_WIDTH-1:0]   busy
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] pend [NREG];
  logic write_hit;
  logic claim_full;
  logic claim_take;

  // Handshake: a claim is taken on a rising edge where claim_valid && claim_ready;
  // claim_ready never depends on claim_valid, so the issue stage may hold valid freely.
  assign write_hit   = wen && (waddr != '0);
  assign claim_full  = (claim_addr != '0) && (pend[claim_addr] == CNT_MAX) &&
                       !(write_hit && (waddr == claim_addr));
  assign claim_ready = !rst && !flush && !claim_full;
  assign claim_take  = claim_valid && claim_ready && (claim_addr != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        // A claim and a writeback to the same register cancel out.
        if (claim_take && (claim_addr == ADDR_WIDTH'(r)) &&
            !(write_hit && (waddr == ADDR_WIDTH'(r))))
          pend[r] <= pend[r] + CNT_ONE;
        else if (write_hit && (waddr == ADDR_WIDTH'(r)) && (pend[r] != '0) &&
                 !(claim_take && (claim_addr == ADDR_WIDTH'(r))))
          pend[r] <= pend[r] - CNT_ONE;
      end
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    if (r == 0) begin : g_zero
      assign busy[r] = 1'b0;
    end else begin : g_reg
`ifdef YSYX_23060184_RF_BYPASS_EN
      assign busy[r] = (pend[r] > CNT_ONE) ||
                       ((pend[r] == CNT_ONE) && !(write_hit && (waddr == ADDR_WIDTH'(r))));
`else
      assign busy[r] = (pend[r] != '0);
`endif
    end
  end

endmodule

// File: rtl/ysyx_23060184_regfile_sb.sv
// Register file with combinational read ports and a pending-writer scoreboard.
// YSYX_23060184_RF_BYPASS_EN forwards same-cycle writeback data to the read ports.
module ysyx_23060184_regfile_sb
  import ysyx_23060184_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR_READ    = DEF_NR_READ,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  input  logic                          claim_valid,
  input  logic [ADDR_WIDTH-1:0]         claim_addr,
  output logic                          claim_ready,
  input  logic                          flush
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]       busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= {DATA_WIDTH{INITIAL_VAL}};
    end else if (wen && (waddr != '0)) begin
      rf[waddr] <= wdata;
    end
  end

  ysyx_23060184_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .wen         (wen),
    .waddr       (waddr),
    .flush       (flush),
    .busy        (busy)
  );

  for (genvar i = 0; i < NR_READ; i++) begin : g_read
    localparam int ALO = slice_lo(i, ADDR_WIDTH);
    localparam int DLO = slice_lo(i, DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] data;
    logic                  port_busy;

    assign ra = raddr[ALO +: ADDR_WIDTH];

    always_comb begin
      data      = rf[ra];
      port_busy = busy[ra];
`ifdef YSYX_23060184_RF_BYPASS_EN
      if (wen && (waddr == ra)) data = wdata;
`endif
      // Index 0 and the reset window always read as empty.
      if (rst || (ra == '0)) begin
        data      = {DATA_WIDTH{INITIAL_VAL}};
        port_busy = 1'b0;
      end
    end

    assign rdata[DLO +: DATA_WIDTH] = data;
    assign rbusy[i]                 = port_busy;
  end

endmodule
